// File: rtl/irq_dispatch_ctrl.sv
// rtl/irq_dispatch_ctrl.sv - interrupt request latch and valid/ready dispatcher
module irq_dispatch_ctrl #(
    parameter int N    = 8,
    parameter bit EDGE = 1'b1,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    output logic            irq_valid,
    output logic [IDXW-1:0] irq_id,
    input  logic            irq_ready,
    input  logic            eoi,
    output logic            busy,
    output logic [N-1:0]    pending_o
);
    typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

    state_t          state;
    logic [N-1:0]    req_q;
    logic [N-1:0]    pending;
    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] sel;
    logic            accept;

    assign rise      = req_i & ~req_q;
    assign cand      = pending & ~mask_i;
    assign accept    = irq_valid && irq_ready;
    assign pending_o = pending;

    always_comb begin
        clr = '0;
        if (accept) clr[irq_id] = 1'b1;
    end

    // Ascending scan: the last set bit seen is the highest-priority one.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) sel = IDXW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            busy      <= 1'b0;
        end else begin
            req_q <= req_i;
            // OR-ing rise after the clear lets a fresh edge survive its own accept.
            if (EDGE) pending <= (pending & ~clr) | rise;
            else      pending <= req_i;

            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        irq_id    <= sel;
                        irq_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (irq_ready) begin
                        irq_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
